// File: rtl/issue_queue_ctrl.sv
// -----------------------------------------------------------------------------
// issue_queue_ctrl
//
// Occupancy and pointer controller for the circular issue queue that sits
// between decode and issue. It does not hold any instruction payload. It
// tracks head, tail and occupancy, produces per-lane write enables and slot
// indices for the storage array, and publishes a free-slot credit that decode
// uses to stall.
//
// Each cycle up to four in-order pushes arrive from decode and up to two
// in-order pops arrive from issue. Both requests are clamped against the
// occupancy registered at the start of the cycle:
//   - A pop cannot consume an entry that is pushed in the same cycle.
//   - A push gets no credit from a same-cycle pop.
// A flush empties the queue in one cycle and overrides any push or pop.
//
// Optional feature, selected by the macro IQ_CTRL_CHECK_EN:
//   defined   - err is a sticky flag. It sets on any non-flush cycle where
//               decode over-pushes or issue over-pops, and a simulation
//               $error reports the same event.
//   undefined - err is tied low and no check logic is built.
// Clamping of the requests is present in both builds.
//
// Parameters:
//   DEPTH   number of queue entries (power of two, >= 8)
//   PTR_W   pointer width, $clog2(DEPTH)
//
// Ports:
//   clk           in   core clock, rising edge
//   rst           in   asynchronous active-high reset
//   push_number   in   [2:0]  pushes requested this cycle (0..4)
//   pop_number    in   [1:0]  pops requested this cycle (0..2)
//   flush         in   empty the queue
//   iq_size_left  out  [2:0]  free-slot credit, saturated at 4
//   wr_en         out  [3:0]  per-lane slot write enable
//   wr_idx        out  [3:0][PTR_W-1:0]  per-lane slot index
//                      (lane k = tail + k, wrapping modulo DEPTH)
//   head_ptr      out  index of the oldest valid entry
//   tail_ptr      out  index of the next free slot
//   count         out  [PTR_W:0]  current occupancy (0..DEPTH)
//   empty         out  count == 0
//   full          out  count == DEPTH
//   err           out  sticky protocol error (0 unless IQ_CTRL_CHECK_EN)
// -----------------------------------------------------------------------------
module issue_queue_ctrl #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            push_number,
  input  logic [1:0]            pop_number,
  input  logic                  flush,
  output logic [2:0]            iq_size_left,
  output logic [3:0]            wr_en,
  output logic [3:0][PTR_W-1:0] wr_idx,
  output logic [PTR_W-1:0]      head_ptr,
  output logic [PTR_W-1:0]      tail_ptr,
  output logic [PTR_W:0]        count,
  output logic                  empty,
  output logic                  full,
  output logic                  err
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] head_ptr_reg, head_ptr_next;
  logic [PTR_W-1:0] tail_ptr_reg, tail_ptr_next;
  logic [CNT_W-1:0] count_reg,    count_next;

  // ---------------------------------------------------------------------------
  // Request clamping
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] push_req;
  logic [CNT_W-1:0] pop_req;
  logic [CNT_W-1:0] push_eff;
  logic [CNT_W-1:0] pop_eff;

  // Widen the requests to count width. PTR_W is at least 3, so CNT_W is at
  // least 4 and both request fields fit.
  assign push_req   = CNT_W'(push_number);
  assign pop_req    = CNT_W'(pop_number);
  assign free_slots = DEPTH_C - count_reg;

  // Both clamps use only the occupancy registered at the start of the cycle.
  // This keeps same-cycle pushes out of reach of pops and gives no pop credit
  // to pushes.
  assign push_eff = (push_req > free_slots) ? free_slots : push_req;
  assign pop_eff  = (pop_req  > count_reg)  ? count_reg  : pop_req;

  // ---------------------------------------------------------------------------
  // Per-lane write enables and slot indices
  // ---------------------------------------------------------------------------
  // Each lane index wraps on its own through the natural PTR_W-bit overflow,
  // so a group of pushes can straddle DEPTH-1 -> 0 within a single cycle. The
  // indices are driven even on lanes whose write enable is low.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wr_idx[gi] = tail_ptr_reg + PTR_W'(gi);
      assign wr_en[gi]  = (push_eff > CNT_W'(gi)) && !flush;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // push_eff is at most 7 and pop_eff is at most 3. Both fit in PTR_W bits
  // (PTR_W >= 3), so the pointer adds can drop the top count bit. The count
  // itself never wraps, because the clamps keep it within 0..DEPTH.
  always_comb begin
    head_ptr_next = head_ptr_reg;
    tail_ptr_next = tail_ptr_reg;
    count_next    = count_reg;
    if (flush) begin
      head_ptr_next = '0;
      tail_ptr_next = '0;
      count_next    = '0;
    end else begin
      tail_ptr_next = tail_ptr_reg + push_eff[PTR_W-1:0];
      head_ptr_next = head_ptr_reg + pop_eff[PTR_W-1:0];
      count_next    = count_reg + push_eff - pop_eff;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      count_reg    <= '0;
    end else begin
      head_ptr_reg <= head_ptr_next;
      tail_ptr_reg <= tail_ptr_next;
      count_reg    <= count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs, all derived from the registered count
  // ---------------------------------------------------------------------------
  // The credit has no path from push_number or pop_number. Decode therefore
  // sees the credit from a pop one cycle after the pop, which is conservative
  // but always safe.
  assign iq_size_left = (free_slots > CNT_W'(4)) ? 3'd4 : free_slots[2:0];
  assign empty        = (count_reg == '0);
  assign full         = (count_reg == DEPTH_C);
  assign head_ptr     = head_ptr_reg;
  assign tail_ptr     = tail_ptr_reg;
  assign count        = count_reg;

  // ---------------------------------------------------------------------------
  // Optional protocol checker
  // ---------------------------------------------------------------------------
`ifdef IQ_CTRL_CHECK_EN
  logic err_reg;
  logic violation;

  // An over-request is an upstream bug even though the clamps keep the state
  // consistent. A flush cycle is exempt because it discards the requests.
  assign violation = !flush && ((push_req > free_slots) || (pop_req > count_reg));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (violation) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && violation) begin
      $error("issue_queue_ctrl: protocol violation push=%0d pop=%0d count=%0d",
             push_number, pop_number, count_reg);
    end
  end
`endif
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_issue_queue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_issue_queue_ctrl
//
// Directed bench for issue_queue_ctrl with DEPTH = 16.
//
// A small reference model (head, tail, count, err) runs alongside the DUT.
// On each step the bench does the following:
//   1. Drives the inputs.
//   2. Checks the combinational outputs against the model's pre-edge state.
//   3. Advances the model and queues the expected post-edge state.
//   4. Pops that expectation after the clock edge and compares it with the
//      DUT registers.
//
// Expected err follows IQ_CTRL_CHECK_EN, so the bench matches either build.
// -----------------------------------------------------------------------------
module tb_issue_queue_ctrl;

  localparam int DEPTH = 16;
  localparam int PTR_W = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [2:0]            push_number = '0;
  logic [1:0]            pop_number = '0;
  logic                  flush = 1'b0;
  logic [2:0]            iq_size_left;
  logic [3:0]            wr_en;
  logic [3:0][PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0]      head_ptr;
  logic [PTR_W-1:0]      tail_ptr;
  logic [PTR_W:0]        count;
  logic                  empty;
  logic                  full;
  logic                  err;

  issue_queue_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .push_number  (push_number),
    .pop_number   (pop_number),
    .flush        (flush),
    .iq_size_left (iq_size_left),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .head_ptr     (head_ptr),
    .tail_ptr     (tail_ptr),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int head;
    int tail;
    int cnt;
    int err;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_mis = 0;

  int m_head = 0;
  int m_tail = 0;
  int m_count = 0;
  int m_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Drive one cycle of requests. Entered and left at posedge + 1.
  task automatic step(input int pn, input int qn, input bit fl);
    exp_t e;
    int pe;
    int we;
    int exp_en;
    push_number = 3'(pn);
    pop_number  = 2'(qn);
    flush       = fl;
    @(negedge clk);

    // Model clamps, computed from the pre-edge occupancy.
    pe     = imin(qn, m_count);
    we     = imin(pn, DEPTH - m_count);
    exp_en = fl ? 0 : ((1 << imin(we, 4)) - 1);

    // Combinational outputs against the pre-edge state.
    chk("wr_en", 32'(wr_en), exp_en);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wr_idx[%0d]", k), 32'(wr_idx[k]), (m_tail + k) % DEPTH);
    end
    chk("iq_size_left", 32'(iq_size_left), imin(DEPTH - m_count, 4));
    chk("empty", 32'(empty), (m_count == 0) ? 1 : 0);
    chk("full", 32'(full), (m_count == DEPTH) ? 1 : 0);

`ifdef IQ_CTRL_CHECK_EN
    if (!fl && ((pn > DEPTH - m_count) || (qn > m_count))) m_err = 1;
`endif

    // Advance the model.
    if (fl) begin
      m_head  = 0;
      m_tail  = 0;
      m_count = 0;
    end else begin
      m_tail  = (m_tail + we) % DEPTH;
      m_head  = (m_head + pe) % DEPTH;
      m_count = m_count + we - pe;
    end

    // Queue the expected post-edge state.
    e.head = m_head;
    e.tail = m_tail;
    e.cnt  = m_count;
    e.err  = m_err;
    sb.push_back(e);

    @(posedge clk);
    #1;

    // Compare the registered state with the queued expectation.
    if (sb.size() == 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk("head_ptr", 32'(head_ptr), e.head);
      chk("tail_ptr", 32'(tail_ptr), e.tail);
      chk("count", 32'(count), e.cnt);
      chk("err", 32'(err), e.err);
    end

    $display("step push=%0d pop=%0d flush=%0d -> head=%0d tail=%0d count=%0d credit=%0d err=%0d",
             pn, qn, fl, head_ptr, tail_ptr, count, iq_size_left, err);
  endtask

  // Assert reset mid-cycle and check the async clear before any clock edge.
  // Returns at posedge + 1.
  task automatic do_reset();
    rst         = 1'b1;
    push_number = '0;
    pop_number  = '0;
    flush       = 1'b0;
    m_head  = 0;
    m_tail  = 0;
    m_count = 0;
    m_err   = 0;
    #1;
    chk("rst head_ptr", 32'(head_ptr), 0);
    chk("rst tail_ptr", 32'(tail_ptr), 0);
    chk("rst count", 32'(count), 0);
    chk("rst iq_size_left", 32'(iq_size_left), 4);
    chk("rst empty", 32'(empty), 1);
    chk("rst full", 32'(full), 0);
    chk("rst err", 32'(err), 0);
    chk("rst wr_en", 32'(wr_en), 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst wr_idx[%0d]", k), 32'(wr_idx[k]), k);
    end
    $display("reset asserted -> head=%0d tail=%0d count=%0d credit=%0d",
             head_ptr, tail_ptr, count, iq_size_left);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    do_reset();

    // Fill the queue with 4 pushes per cycle: lanes 0-3, 4-7, 8-11, 12-15.
    for (int i = 0; i < 4; i++) step(4, 0, 1'b0);
    step(0, 0, 1'b0);  // full = 1 and iq_size_left = 0 at count 16

    // Push/pop straddling the wrap point at count 14, tail 14.
    do_reset();
    step(4, 0, 1'b0);
    step(4, 0, 1'b0);
    step(4, 0, 1'b0);
    step(2, 0, 1'b0);
    step(2, 2, 1'b0);  // wr_en 0011, lanes 14/15, tail wraps to 0
    step(0, 0, 1'b0);  // credit still 2

    // Over-push at count 14: only 2 lanes are enabled and count reaches 16.
    step(4, 0, 1'b0);
    step(0, 2, 1'b0);  // simultaneous push-free pop at full

    // Over-pop at count 1.
    do_reset();
    step(1, 0, 1'b0);
    step(0, 2, 1'b0);
    step(0, 0, 1'b0);  // empty = 1

    // Flush at count 9 overrides push 3 / pop 2.
    do_reset();
    step(4, 0, 1'b0);
    step(4, 0, 1'b0);
    step(1, 0, 1'b0);
    step(3, 2, 1'b1);
    step(0, 0, 1'b0);  // credit back to 4

    // Asynchronous reset mid-cycle at count 7.
    step(4, 0, 1'b0);
    step(3, 0, 1'b0);
    #2;
    do_reset();

    // Mixed traffic, including clamped requests, wrap and occasional flush.
    for (int i = 0; i < 30; i++) begin
      step($urandom_range(0, 4), $urandom_range(0, 2), ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/issue_queue_ctrl.md
# issue_queue_ctrl

Occupancy and pointer controller for the 16-entry circular issue queue between decode and issue. Each cycle it accepts up to four in-order pushes from decode and up to two in-order pops from issue. It maintains the head and tail pointers and the occupancy count, generates per-lane slot write enables and indices for the queue storage, and publishes the `iq_size_left` credit that decode uses to stall. A flush empties the queue in one cycle.

## Interface
- `DEPTH`, 16, number of queue entries; must be a power of two, ≥ 8.
- `PTR_W`, $clog2(DEPTH), pointer width.
- `clk` in 1, core clock; all state updates on rising edge.
- `rst` in 1, asynchronous, active-high reset.
- `push_number` in 3, instructions decode pushes this cycle (0..4).
- `pop_number` in 2, instructions issue removes from head this cycle (0..2).
- `flush` in 1, pipeline flush; empties queue.
- `iq_size_left` out 3, free-slot credit to decode, saturated at 4.
- `wr_en` out 4, per-lane slot write enable.
- `wr_idx` out 4×PTR_W, per-lane slot index; lane k = (tail_ptr + k) mod DEPTH.
- `head_ptr` out PTR_W, index of oldest valid entry.
- `tail_ptr` out PTR_W, index of next free slot.
- `count` out PTR_W+1, current occupancy (0..DEPTH).
- `empty` out 1, count == 0.
- `full` out 1, count == DEPTH.
- `err` out 1, sticky protocol error (see Configuration).

## Operation
- State registers: `head_ptr`, `tail_ptr`, `count`, and the `err` sticky bit.
- Effective pop: `pop_eff = min(pop_number, count)`, using the registered count. Entries pushed in the same cycle cannot be popped that cycle.
- Effective push: `push_eff = min(push_number, DEPTH − count)`, using the registered count. No same-cycle pop credit is given.
- `wr_en[k] = (k < push_eff) && !flush`. `wr_idx[k]` is always driven, whether or not the lane is enabled.
- Update with no flush:
  - `tail_ptr += push_eff` mod DEPTH.
  - `head_ptr += pop_eff` mod DEPTH.
  - `count += push_eff − pop_eff`.
- Update on flush: `head_ptr = tail_ptr = count = 0`. Flush overrides any push or pop in the same cycle.
- `iq_size_left = min(DEPTH − count, 4)`. This is combinational from the registered count and has no combinational path from `push_number` or `pop_number`.
- `empty` and `full` are combinational from the registered count.
- Pointer arithmetic is modulo DEPTH by natural PTR_W-bit wrap. Count arithmetic is PTR_W+1 bits and never wraps, because the clamps guarantee 0 ≤ count ≤ DEPTH.

## Timing
- Reset values: `head_ptr` = 0, `tail_ptr` = 0, `count` = 0, `iq_size_left` = 4, `empty` = 1, `full` = 0, `err` = 0, `wr_en` = 0. `wr_idx` lane k = k.
- Reset mid-operation: all state clears immediately (asynchronous). The first update after reset occurs on the first rising edge after `rst` deasserts.
- Write enables and indices are valid in the same cycle as `push_number`. Storage captures on that edge.
- A pushed entry becomes visible at `head_ptr` and is poppable from the next cycle.
- Credit released by a pop becomes visible in `iq_size_left` one cycle later, so the credit is conservative.
- Wrap-around: a push crossing index DEPTH−1 continues at 0 within the same cycle. Lanes may wrap individually.
- Simultaneous push and pop at full: `push_eff` = 0 even if `pop_number` > 0.

## Configuration
- Macro `IQ_CTRL_CHECK_EN`.
- Defined:
  - `err` sets and holds (until `rst`) when `push_number > DEPTH − count` or `pop_number > count` in any non-flush cycle.
  - A simulation `$error` fires on the same condition.
- Undefined:
  - `err` is tied to 0 and no check logic is built.
  - Clamping of `push_eff` and `pop_eff` is present in both builds.

## Test plan
- Reset, then push 4 per cycle for 4 cycles: `wr_idx` sequences 0-3, 4-7, 8-11, 12-15; final `count` = 16, `full` = 1, `iq_size_left` = 0, `tail_ptr` = 0.
- With `count` = 14 and `tail_ptr` = 14, push 2 and pop 2 simultaneously: `wr_en` = 0011, `wr_idx` lanes 0 and 1 = 14 and 15; next `count` = 14, `tail_ptr` = 0, `head_ptr` += 2; `iq_size_left` = 2 in both cycles.
- With `count` = 1, request pop 2 and push 0: `pop_eff` = 1, next `count` = 0, `empty` = 1; `err` = 1 with `IQ_CTRL_CHECK_EN` defined, 0 without.
- With `count` = 14, push 4 (protocol violation): only lanes 0 and 1 are enabled, next `count` = 16, and `err` sets when the macro is defined.
- With `count` = 9, assert `flush` together with push 3 and pop 2: `wr_en` = 0000; next `head_ptr` = `tail_ptr` = 0, `count` = 0, `iq_size_left` = 4.
- Assert `rst` asynchronously mid-cycle with `count` = 7: all outputs return to reset values before the next clock edge.
